// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the byte-addressable data memory port.
// Accepts one load/store per handshake from execute and checks funct3 and alignment.
// Drives the memory control signals, captures the registered read data, and returns
// the result to writeback over a valid/ready handshake.
// Optional feature: define LSU_BOUNDS_CHECK_EN to reject accesses beyond MEMORY_SIZE
// (flagged on resp_oob). When it is undefined, resp_oob is tied to 0.
module load_store_unit #(
  parameter int MEMORY_SIZE = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic        resp_oob,
  output logic [31:0] mem_Din,
  output logic [31:0] mem_WR_Addr,
  output logic [31:0] mem_RD_Addr,
  output logic [1:0]  mem_WE,
  output logic [2:0]  mem_RD_Type,
  input  logic [31:0] mem_Dout
);

  typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_CAPT, ST_WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  funct3_q;
  logic        accept;
  logic        f_illegal, f_misaligned, f_oob, fault;

  assign accept = req_valid && (state == IDLE);

  // Classify the incoming request; the result is used only on the accept edge.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    f_illegal    = 1'b0;
    f_misaligned = 1'b0;
    if (req_is_store)
      f_illegal = (req_funct3 > 3'b010);
    else
      f_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    if (!f_illegal)
      f_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

`ifdef LSU_BOUNDS_CHECK_EN
  logic [32:0] access_end;
  logic [32:0] access_size;

  // End address is computed in 33 bits, so an access near 0xFFFFFFFF cannot wrap into range.
  always_comb begin
    access_size = 33'd4;
    case (req_funct3[1:0])
      2'b00:   access_size = 33'd1;
      2'b01:   access_size = 33'd2;
      default: access_size = 33'd4;
    endcase
    access_end = {1'b0, req_addr} + access_size;
    f_oob      = !f_illegal && !f_misaligned && (access_end > 33'(MEMORY_SIZE));
  end
`else
  assign f_oob = 1'b0;
`endif

  assign fault = f_illegal || f_misaligned || f_oob;

  // State register.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (fault)             state_nxt = DONE;
        else if (req_is_store) state_nxt = ST_WRITE;
        else                   state_nxt = LD_ISSUE;
      end
      LD_ISSUE: state_nxt = LD_CAPT;
      LD_CAPT:  state_nxt = DONE;
      ST_WRITE: state_nxt = DONE;
      DONE:     if (resp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Handshake outputs and write strobe. WE is gated by Rst so a reset during ST_WRITE commits nothing.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
    mem_WE     = 2'b00;
    if ((state == ST_WRITE) && !Rst) begin
      case (funct3_q[1:0])
        2'b00:   mem_WE = 2'b01;
        2'b01:   mem_WE = 2'b10;
        default: mem_WE = 2'b11;
      endcase
    end
  end

  // Datapath registers. Memory addresses are loaded on accept, so they are valid throughout LD_ISSUE/ST_WRITE.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      funct3_q        <= 3'b000;
      resp_rdata      <= 32'h0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      resp_oob        <= 1'b0;
      mem_Din         <= 32'h0;
      mem_WR_Addr     <= 32'h0;
      mem_RD_Addr     <= 32'h0;
      mem_RD_Type     <= 3'b000;
    end else begin
      if (accept) begin
        funct3_q        <= req_funct3;
        resp_rdata      <= 32'h0;
        resp_illegal    <= f_illegal;
        resp_misaligned <= f_misaligned;
        resp_oob        <= f_oob;
        if (!fault) begin
          if (req_is_store) begin
            mem_WR_Addr <= req_addr;
            mem_Din     <= req_wdata;
          end else begin
            mem_RD_Addr <= req_addr;
            mem_RD_Type <= req_funct3;
          end
        end
      end
      if (state == LD_CAPT) resp_rdata <= mem_Dout;
    end
  end

endmodule
